// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus scheduler.
package lcd_pkg;

    // Bus-cycle phases of one LCD transaction.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } lcd_state_t;

    // Default timing in clock cycles (50 MHz system clock).
    localparam int unsigned DEF_T_SETUP = 3;
    localparam int unsigned DEF_T_PULSE = 25;
    localparam int unsigned DEF_T_HOLD  = 3;
    localparam int unsigned DEF_T_SHORT = 2000;   // 39 us, rounded up
    localparam int unsigned DEF_T_LONG  = 76500;  // 1.53 ms

    // RS pin meaning.
    localparam logic RS_DATA = 1'b1;
    localparam logic RS_CMD  = 1'b0;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd_byte);
        return (rs == RS_CMD) && (cmd_byte[7:2] == 6'd0) && (cmd_byte != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter with its own last-grant pointer.
module lcd_rr_arbiter
    import lcd_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic       Update,
    output logic [1:0] Grant
);

    // 1 = requester 1 was granted last; resets to 1 so requester 0 wins first.
    logic last_grant;

    // Pick a single winner; on contention favour the one not granted last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        Grant = 2'b00;
        unique case (Req)
            2'b01:   Grant = 2'b01;
            2'b10:   Grant = 2'b10;
            2'b11:   Grant = last_grant ? 2'b01 : 2'b10;
            default: Grant = 2'b00;
        endcase
    end

    // Remember the winner only when the grant is actually taken.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_grant <= 1'b1;
        end else if (Update && (Grant != 2'b00)) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            last_grant <= Grant[1];
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the LCD bus after initialization: arbitrates two requesters, drives
// RS/RW/E/DATA with setup/pulse/hold timing, then waits out execution time.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_SHORT = DEF_T_SHORT,
    parameter int unsigned T_LONG  = DEF_T_LONG
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Init_Done,
    input  logic [1:0] Req,
    input  logic [1:0] Req_RS,
    input  logic [7:0] Req_Data0,
    input  logic [7:0] Req_Data1,
    output logic [1:0] Ack,
    output logic [1:0] Done,
    output logic       Busy,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    lcd_state_t  state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        owner, owner_n;
    logic        rs_n;
    logic [7:0]  data_n;
    logic        en_n;
    logic [1:0]  ack_n, done_n;
    logic        busy_n;
    logic [1:0]  grant;
    logic        arb_update;

    // The bus is write-only.
    assign LCD_RW = 1'b0;

    lcd_rr_arbiter u_arb (
        .Clock  (Clock),
        .Reset  (Reset),
        .Req    (Req & {2{Init_Done}}),
        .Update (arb_update),
        .Grant  (grant)
    );

    // Next-state, phase counter and registered-output values.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        owner_n    = owner;
        rs_n       = LCD_RS;
        data_n     = LCD_DATA;
        en_n       = LCD_EN;
        ack_n      = 2'b00;
        done_n     = 2'b00;
        arb_update = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    arb_update = 1'b1;
                    owner_n    = grant[1];
                    rs_n       = grant[1] ? Req_RS[1] : Req_RS[0];
                    data_n     = grant[1] ? Req_Data1 : Req_Data0;
                    ack_n      = grant;
                    cnt_n      = T_SETUP - 1;
                    state_n    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == 32'd0) begin
                    en_n    = 1'b1;
                    cnt_n   = T_PULSE - 1;
                    state_n = ST_PULSE;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == 32'd0) begin
                    en_n    = 1'b0;
                    cnt_n   = T_HOLD - 1;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 32'd0) begin
                    cnt_n   = is_long_cmd(LCD_RS, LCD_DATA) ? (T_LONG - 1) : (T_SHORT - 1);
                    state_n = ST_WAIT;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            ST_WAIT: begin
                if (cnt == 32'd0) begin
                    done_n  = owner ? 2'b10 : 2'b01;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State, counter, capture registers and all pin outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: every register here is reset so an aborted transaction leaves no trace on the pins.
            state    <= ST_IDLE;
            cnt      <= 32'd0;
            owner    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
            LCD_EN   <= 1'b0;
            Ack      <= 2'b00;
            Done     <= 2'b00;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            owner    <= owner_n;
            LCD_RS   <= rs_n;
            LCD_DATA <= data_n;
            LCD_EN   <= en_n;
            Ack      <= ack_n;
            Done     <= done_n;
            Busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: a per-cycle timeline model of
// each transaction plus directed and randomized requester traffic.
module tb_lcd_bus_scheduler;

    localparam int S  = 3;
    localparam int P  = 25;
    localparam int H  = 3;
    localparam int TS = 60;
    localparam int TL = 500;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Init_Done = 1'b0;
    logic [1:0] Req = 2'b00;
    logic [1:0] Req_RS = 2'b00;
    logic [7:0] Req_Data0 = 8'h00;
    logic [7:0] Req_Data1 = 8'h00;
    logic [1:0] Ack, Done;
    logic       Busy, LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    int errors = 0;
    int checks = 0;

    // Transaction timeline model: m_t counts edges since capture.
    bit         m_busy, m_last, m_owner, m_rs;
    int         m_t, m_total;
    logic [7:0] m_data;
    logic [1:0] e_ack, e_done;

    lcd_bus_scheduler #(
        .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_SHORT(TS), .T_LONG(TL)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Init_Done(Init_Done), .Req(Req),
        .Req_RS(Req_RS), .Req_Data0(Req_Data0), .Req_Data1(Req_Data1),
        .Ack(Ack), .Done(Done), .Busy(Busy), .LCD_EN(LCD_EN),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_owner = 0; m_rs = 0; m_t = 0; m_total = 0;
        m_data = 8'h00; e_ack = 2'b00; e_done = 2'b00;
    endtask

    task automatic model_step();
        bit own;
        int wait_len;
        if (!Reset) begin
            model_reset();
        end else begin
            e_ack = 2'b00; e_done = 2'b00;
            if (m_busy) begin
                m_t++;
                if (m_t == m_total) begin
                    m_busy = 0;
                    e_done = m_owner ? 2'b10 : 2'b01;
                end
            end else if (Init_Done && Req != 2'b00) begin
                own      = (Req == 2'b11) ? !m_last : Req[1];
                m_last   = own;
                m_owner  = own;
                m_rs     = Req_RS[own];
                m_data   = own ? Req_Data1 : Req_Data0;
                wait_len = (!m_rs && m_data >= 8'd1 && m_data <= 8'd3) ? TL : TS;
                m_total  = S + P + H + wait_len;
                m_t      = 0;
                m_busy   = 1;
                e_ack    = own ? 2'b10 : 2'b01;
            end
        end
    endtask

    task automatic check_all();
        check("ack", Ack, e_ack);
        check("done", Done, e_done);
        check("busy", Busy, m_busy);
        check("lcd_en", LCD_EN, m_busy && m_t >= S && m_t < S + P);
        check("lcd_rs", LCD_RS, m_rs);
        check("lcd_data", LCD_DATA, m_data);
        check("lcd_rw", LCD_RW, 1'b0);
    endtask

    // One clock: model at the edge, compare at the falling edge, requesters drop on Ack.
    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        check_all();
        for (int i = 0; i < 2; i++) if (e_ack[i]) Req[i] = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((m_busy || Busy) && n < budget) begin tick(); n++; end
        check("idle_reached", Busy, 1'b0);
    endtask

    task automatic run_txn(input int budget, output int ack_at, output int en_start,
                           output int en_len, output int done_at, output int busy_len);
        ack_at = -1; en_start = -1; en_len = 0; done_at = -1; busy_len = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (Ack != 2'b00 && ack_at < 0) ack_at = c;
            if (LCD_EN) begin en_len++; if (en_start < 0) en_start = c; end
            if (Busy) busy_len++;
            if (Done != 2'b00) begin done_at = c; break; end
        end
    endtask

    initial begin
        int ack_at, en_start, en_len, done_at, busy_len, cnt, n;
        int obs_g[4];
        logic [1:0] seen;

        // Reset values.
        model_reset();
        #1;
        check_all();
        repeat (3) tick();
        Reset = 1'b1;

        // Requests ignored while the initializer is not done.
        Req = 2'b01; Req_RS = 2'b01; Req_Data0 = 8'h41;
        cnt = 0;
        repeat (100) begin tick(); if (Ack != 2'b00) cnt++; end
        check("no_ack_before_init", cnt, 0);

        // Single data write from requester 0.
        Init_Done = 1'b1;
        run_txn(400, ack_at, en_start, en_len, done_at, busy_len);
        check("w41_ack_at", ack_at, 0);
        check("w41_en_start", en_start - ack_at, S);
        check("w41_en_len", en_len, P);
        check("w41_done_at", done_at - ack_at, S + P + H + TS);
        run_idle(10);

        // Requester 1 commands: clear (long) then display control (short).
        Req_RS = 2'b00; Req_Data1 = 8'h01; Req = 2'b10;
        run_txn(1000, ack_at, en_start, en_len, done_at, busy_len);
        check("clear_busy_len", busy_len, S + P + H + TL);
        run_idle(10);
        Req_Data1 = 8'h0C; Req = 2'b10;
        run_txn(1000, ack_at, en_start, en_len, done_at, busy_len);
        check("ctrl_busy_len", busy_len, S + P + H + TS);
        run_idle(10);

        // Both held continuously: grants must alternate starting with 0.
        Req_RS = 2'b11; Req_Data0 = 8'h30; Req_Data1 = 8'h31;
        for (int k = 0; k < 4; k++) obs_g[k] = -1;
        n = 0; cnt = 0; Req = 2'b11;
        while (cnt < 4 && n < 2000) begin
            tick(); n++;
            if (Ack == 2'b01) begin obs_g[cnt] = 0; cnt++; end
            else if (Ack == 2'b10) begin obs_g[cnt] = 1; cnt++; end
            if (cnt < 4) Req = 2'b11;
        end
        Req = 2'b00;
        for (int k = 0; k < 4; k++) check($sformatf("rr_grant_%0d", k), obs_g[k], k % 2);
        run_idle(200);

        // Asynchronous reset while E is high; pointer must return to favour 0.
        Req_Data0 = 8'h55; Req = 2'b01;
        n = 0;
        while (!LCD_EN && n < 50) begin tick(); n++; end
        check("en_reached", LCD_EN, 1'b1);
        tick();
        #2 Reset = 1'b0;
        model_reset();
        #1;
        check("async_en", LCD_EN, 1'b0);
        check("async_busy", Busy, 1'b0);
        check("async_data", LCD_DATA, 8'h00);
        @(negedge Clock);
        Req = 2'b00;
        repeat (3) tick();
        Reset = 1'b1;
        cnt = 0;
        repeat (150) begin tick(); if (Done != 2'b00) cnt++; end
        check("no_done_after_abort", cnt, 0);
        Req = 2'b11;
        seen = 2'b00; n = 0;
        while (seen == 2'b00 && n < 10) begin tick(); n++; seen = Ack; end
        Req[1] = 1'b0;
        check("post_reset_grant", seen, 2'b01);
        run_idle(200);

        // Init_Done falling during WAIT: finish the write, hold off requester 1.
        Req_RS = 2'b11; Req_Data0 = 8'h41; Req = 2'b01;
        n = 0;
        while (!(m_busy && m_t > S + P + H) && n < 100) begin tick(); n++; end
        Init_Done = 1'b0;
        Req[1] = 1'b1; Req_Data1 = 8'h22;
        seen = 2'b00; n = 0;
        while (seen == 2'b00 && n < 200) begin tick(); n++; seen = Done; end
        check("done_after_init_drop", seen, 2'b01);
        cnt = 0;
        repeat (20) begin tick(); if (Ack != 2'b00) cnt++; end
        check("no_ack_init_low", cnt, 0);
        Init_Done = 1'b1;
        seen = 2'b00; n = 0;
        while (seen == 2'b00 && n < 10) begin tick(); n++; seen = Ack; end
        check("ack_after_init_return", seen, 2'b10);
        run_idle(200);

        // Randomized requester traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!Req[i] && $urandom_range(0, 15) == 0) begin
                    Req[i]    = 1'b1;
                    Req_RS[i] = 1'($urandom_range(0, 1));
                    if (i == 0) Req_Data0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                    else        Req_Data1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                end else if (Req[i] && $urandom_range(0, 63) == 0) begin
                    Req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 199) == 0) Init_Done = !Init_Done;
        end
        Req = 2'b00; Init_Done = 1'b1;
        run_idle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
